// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request, holds the fetched word for decode, squashes stale responses on redirect.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (aligns redirect targets and flags misaligned ones on fetch_misalign).
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallf,
    input  logic        redirect,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrf,
    output logic [31:0] pcf,
    output logic [31:0] pc_4f,
    output logic        fetch_wait
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HAVE = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] addr_r;
    logic [31:0] instr_r;
    logic [31:0] target_s;
    logic        load_addr_s;
    logic        capture_s;

    // Redirect target conditioning
`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_s;
    logic misalign_r;

    always_comb begin
        target_s   = {pc_target[31:2], 2'b00};
        misalign_s = redirect && (pc_target[1:0] != 2'b00);
    end
`else
    always_comb begin
        target_s = pc_target;
    end
`endif

    // Next-state and capture decision
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        case (state_r)
            S_IDLE: state_next_s = S_REQ;
            S_REQ: begin
                if (redirect) begin
                    // a response arriving with the redirect is simply dropped; otherwise one is still owed
                    if (imem_ready) begin
                        state_next_s = S_REQ;
                    end else begin
                        state_next_s = S_DROP;
                    end
                end else if (imem_ready) begin
                    state_next_s = S_HAVE;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_HAVE: begin
                if (redirect) begin
                    state_next_s = S_REQ;
                end else if (stallf) begin
                    state_next_s = S_HAVE;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_ready) begin
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_DROP;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Program counter update and request-address load strobe
    always_comb begin
        pc_next_s = pc_r;
        if (redirect) begin
            pc_next_s = target_s;
        end else if ((state_r == S_HAVE) && !stallf) begin
            pc_next_s = pc_r + 32'd4;
        end else begin
            pc_next_s = pc_r;
        end
        // address is only reloaded when a fresh request starts, never while one is waiting
        load_addr_s = (state_next_s == S_REQ) && !((state_r == S_REQ) && !imem_ready);
    end

    // State, pc, address and instruction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            addr_r  <= RESET_PC;
            instr_r <= NOP_INSTR;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (load_addr_s) begin
                addr_r <= pc_next_s;
            end
            if (capture_s) begin
                instr_r <= imem_rdata;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // One-cycle misalignment flag following each misaligned redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_s;
        end
    end

    // Misalignment flag output
    always_comb begin
        fetch_misalign = misalign_r;
    end
`endif

    // Pipeline-facing outputs decoded from registered state
    always_comb begin
        imem_req   = (state_r == S_REQ);
        imem_addr  = addr_r;
        pcf        = pc_r;
        pc_4f      = pc_r + 32'd4;
        fetch_wait = (state_r != S_HAVE);
        if (state_r == S_HAVE) begin
            instrf = instr_r;
        end else begin
            instrf = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected request addresses and fetched
// instructions; a negedge monitor pops and compares them as the DUT accepts responses and presents words.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stallf;
    logic        redirect;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instrf;
    logic [31:0] pcf;
    logic [31:0] pc_4f;
    logic        fetch_wait;

    logic        stallf2;
    logic        redirect2;
    logic [31:0] pc_target2;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_ready2;
    logic [31:0] imem_rdata2;
    logic [31:0] instrf2;
    logic [31:0] pcf2;
    logic [31:0] pc_4f2;
    logic        fetch_wait2;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
    logic        fetch_misalign2;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_t;

    logic [31:0] exp_addr_q[$];
    fetch_t      exp_fetch_q[$];
    int          total;
    int          bad;
    logic        prev_wait;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stallf(stallf), .redirect(redirect), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instrf(instrf), .pcf(pcf), .pc_4f(pc_4f), .fetch_wait(fetch_wait)
`ifdef FETCH_MISALIGN_CHK_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut2 (
        .clk(clk), .rst(rst), .stallf(stallf2), .redirect(redirect2), .pc_target(pc_target2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2), .imem_rdata(imem_rdata2),
        .instrf(instrf2), .pcf(pcf2), .pc_4f(pc_4f2), .fetch_wait(fetch_wait2)
`ifdef FETCH_MISALIGN_CHK_EN
        , .fetch_misalign(fetch_misalign2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] instr);
        fetch_t f;
        f.instr = instr;
        f.pc    = addr;
        f.pc4   = addr + 32'd4;
        exp_addr_q.push_back(addr);
        exp_fetch_q.push_back(f);
    endtask

    // Monitor: accepted responses check the request address, newly valid words check the decode outputs
    initial begin
        fetch_t f;
        logic [31:0] a;
        prev_wait = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && imem_ready && imem_req && !redirect) begin
                if (exp_addr_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("req_addr", imem_addr, a);
                end
            end
            if (!rst && prev_wait && !fetch_wait) begin
                if (exp_fetch_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_fetch: got instr %h expected none", instrf);
                end else begin
                    f = exp_fetch_q.pop_front();
                    chk("fetch_instr", instrf, f.instr);
                    chk("fetch_pc", pcf, f.pc);
                    chk("fetch_pc4", pc_4f, f.pc4);
                end
            end
            prev_wait = fetch_wait;
        end
    end

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; stallf = 1'b0; redirect = 1'b0; pc_target = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        stallf2 = 1'b0; redirect2 = 1'b0; pc_target2 = 32'd0; imem_ready2 = 1'b0; imem_rdata2 = 32'd0;

        // reset state, with redirect/ready asserted to show reset wins
        tick();
        redirect = 1'b1; pc_target = 32'h40; imem_ready = 1'b1;
        tick();
        redirect = 1'b0; imem_ready = 1'b0;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_wait", {31'd0, fetch_wait}, 32'd1);
        chk("rst_instr", instrf, NOP);
        chk("rst_pcf", pcf, 32'd0);
        chk("rst_pc4", pc_4f, 32'd4);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst2_pc4", pc_4f2, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
`endif

        // first fetch, then hold with stall
        rst = 1'b0;
        tick();
        chk("req0_req", {31'd0, imem_req}, 32'd1);
        expect_fetch(32'd0, 32'h00500093);
        imem_ready = 1'b1; imem_rdata = 32'h00500093; stallf = 1'b1;
        imem_ready2 = 1'b1; imem_rdata2 = 32'h00100073; stallf2 = 1'b1;
        tick();
        imem_ready = 1'b0; imem_ready2 = 1'b0;
        chk("wrap_pcf", pcf2, 32'hFFFFFFFC);
        chk("wrap_pc4", pc_4f2, 32'h00000000);
        chk("wrap_instr", instrf2, 32'h00100073);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", instrf, 32'h00500093);
            chk("stall_pcf", pcf, 32'd0);
            chk("stall_wait", {31'd0, fetch_wait}, 32'd0);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stallf = 1'b0; stallf2 = 1'b0;
        tick();
        chk("adv_addr", imem_addr, 32'd4);
        chk("adv_instr", instrf, NOP);
        chk("wrap_adv_addr", imem_addr2, 32'd0);

        // second fetch after one wait cycle, then free-run to next request
        expect_fetch(32'd4, 32'h00a00113);
        tick();
        imem_ready = 1'b1; imem_rdata = 32'h00a00113;
        tick();
        imem_ready = 1'b0;
        tick();
        chk("seq_addr", imem_addr, 32'd8);

        // redirect while waiting: DROP, discard one response
        redirect = 1'b1; pc_target = 32'h80;
        tick();
        redirect = 1'b0;
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        chk("drop_addr_hold", imem_addr, 32'd8);
        chk("drop_pcf", pcf, 32'h80);
        tick();
        imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ready = 1'b0;
        chk("after_drop_addr", imem_addr, 32'h80);
        expect_fetch(32'h80, 32'h11111111);
        imem_ready = 1'b1; imem_rdata = 32'h11111111; stallf = 1'b1;
        tick();
        imem_ready = 1'b0;

        // redirect beats stall in HAVE
        redirect = 1'b1; pc_target = 32'h200;
        tick();
        redirect = 1'b0;
        chk("redir_stall_wait", {31'd0, fetch_wait}, 32'd1);
        chk("redir_stall_pcf", pcf, 32'h200);
        chk("redir_stall_addr", imem_addr, 32'h200);

        // redirect coinciding with a response: discard and re-request
        redirect = 1'b1; pc_target = 32'h300; imem_ready = 1'b1; imem_rdata = 32'hCAFEF00D;
        tick();
        redirect = 1'b0; imem_ready = 1'b0;
        chk("redir_rdy_addr", imem_addr, 32'h300);
        chk("redir_rdy_wait", {31'd0, fetch_wait}, 32'd1);

        // redirects inside DROP only move pc
        redirect = 1'b1; pc_target = 32'h340;
        tick();
        pc_target = 32'h400;
        tick();
        redirect = 1'b0;
        chk("drop2_addr", imem_addr, 32'h300);
        chk("drop2_pcf", pcf, 32'h400);
        imem_ready = 1'b1; imem_rdata = 32'hBADBAD00;
        tick();
        imem_ready = 1'b0;
        chk("drop2_new_addr", imem_addr, 32'h400);
        expect_fetch(32'h400, 32'h22222222);
        imem_ready = 1'b1; imem_rdata = 32'h22222222;
        tick();
        imem_ready = 1'b0;

        // reset in DROP
        stallf = 1'b0;
        tick();
        chk("pre_drop_addr", imem_addr, 32'h404);
        redirect = 1'b1; pc_target = 32'h500;
        tick();
        rst = 1'b1; imem_ready = 1'b1; pc_target = 32'h600;
        tick();
        redirect = 1'b0; imem_ready = 1'b0;
        chk("rst_drop_req", {31'd0, imem_req}, 32'd0);
        chk("rst_drop_pcf", pcf, 32'd0);
        chk("rst_drop_instr", instrf, NOP);
        rst = 1'b0;
        tick();
        chk("rst_drop_addr", imem_addr, 32'd0);
        chk("rst_drop_req1", {31'd0, imem_req}, 32'd1);
        chk("rst2_addr", imem_addr2, 32'hFFFFFFFC);
        expect_fetch(32'd0, 32'h33333333);
        imem_ready = 1'b1; imem_rdata = 32'h33333333; stallf = 1'b1;
        tick();
        imem_ready = 1'b0;

        // misaligned redirect target
        redirect = 1'b1; pc_target = 32'h103;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_pcf", pcf, 32'h100);
        chk("mis_pulse", {31'd0, fetch_misalign}, 32'd1);
        tick();
        chk("mis_pulse_end", {31'd0, fetch_misalign}, 32'd0);
`else
        chk("raw_addr", imem_addr, 32'h103);
        chk("raw_pcf", pcf, 32'h103);
        tick();
`endif
        tick();
        chk("addr_q_empty", exp_addr_q.size(), 32'd0);
        chk("fetch_q_empty", exp_fetch_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, is the instruction word presented while no fetched instruction is valid.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, is the synchronous, active-high reset.
REQ-005 Port stallf, input, 1 bit, from the hazard unit; when high, the held instruction SHALL NOT advance.
REQ-006 Port redirect, input, 1 bit, carries a taken branch or jump from the execute stage.
REQ-007 Port pc_target, input, 32 bits, is the redirect address.
REQ-008 Port imem_req, output, 1 bit, is the instruction-memory read request.
REQ-009 Port imem_addr, output, 32 bits, is the registered request address.
REQ-010 Port imem_ready, input, 1 bit, is a one-cycle pulse meaning imem_rdata is valid for the outstanding request.
REQ-011 Port imem_rdata, input, 32 bits, is the instruction-memory read data.
REQ-012 Ports instrf, pcf and pc_4f, outputs, 32 bits each, SHALL drive the fetch/decode pipeline register.
REQ-013 Port fetch_wait, output, 1 bit, SHALL be high whenever instrf does not hold a valid fetched instruction.
REQ-014 Port fetch_misalign, output, 1 bit, SHALL exist only when the configuration macro is defined (REQ-033).

Function
REQ-015 FSM states: IDLE, REQ, HAVE, DROP.
REQ-016 IDLE -> REQ unconditionally on the next edge; imem_ready SHALL be ignored in IDLE.
REQ-017 On entry to REQ, the block SHALL latch the address register from pc.
- imem_req=1 throughout REQ.
- imem_addr SHALL stay stable from request until imem_ready.
REQ-018 REQ with imem_ready=1 and redirect=0: capture imem_rdata into the instruction register; -> HAVE.
REQ-019 REQ with imem_ready=0 and redirect=0: remain in REQ.
REQ-020 HAVE outputs: instrf = captured word; pcf = pc; pc_4f = pc+4; fetch_wait=0; imem_req=0.
REQ-021 HAVE with stallf=1: hold pc, the instruction register and all outputs.
REQ-022 HAVE with stallf=0: pc <= pc+4; -> REQ (minimum 2 cycles per instruction).
REQ-023 Any state except HAVE: instrf=NOP_INSTR, pcf=pc, pc_4f=pc+4, fetch_wait=1.
REQ-024 redirect=1 SHALL set pc <= pc_target and SHALL take priority over stallf.
- IDLE/HAVE -> REQ.
- REQ with imem_ready=1 -> discard data, -> REQ.
- REQ with imem_ready=0 -> DROP.
- DROP -> stay in DROP.
REQ-025 DROP: imem_req=0 and imem_addr held; on imem_ready the data SHALL be discarded, -> REQ.
REQ-026 A redirect arriving in DROP SHALL overwrite pc only; exactly one response is still discarded.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-028 No more than one request SHALL be outstanding at any time.

Reset
REQ-029 rst=1 at a clock edge SHALL set: state=IDLE, pc=RESET_PC, address register=RESET_PC, instruction register=NOP_INSTR.
REQ-030 After reset: imem_req=0, fetch_wait=1, instrf=NOP_INSTR, pcf=RESET_PC, pc_4f=RESET_PC+4, fetch_misalign=0.
REQ-031 Reset SHALL override redirect, stallf and imem_ready in every state, including REQ and DROP mid-transaction.
REQ-032 Instruction memory SHALL share rst, so no stale response follows reset.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHK_EN defined: a redirect with pc_target[1:0]!=0 SHALL load {pc_target[31:2],2'b00} and pulse fetch_misalign high for exactly one cycle.
REQ-034 Macro FETCH_MISALIGN_CHK_EN undefined: pc_target SHALL load unmodified and the fetch_misalign port SHALL be absent.

Verification
REQ-035 Reset, then imem_ready on cycle 2 with rdata=32'h00500093 -> imem_addr=0, instrf=32'h00500093, pcf=0, pc_4f=4, fetch_wait=0.
REQ-036 Hold stallf=1 for 3 cycles in HAVE -> outputs constant and imem_req=0; stallf=0 -> next imem_addr=4.
REQ-037 redirect=1 with pc_target=32'h80, while REQ is waiting -> DROP; response discarded; next imem_addr=32'h80.
REQ-038 redirect=1 with stallf=1 in HAVE -> pc=target and fetch_wait=1 on the next cycle.
REQ-039 With RESET_PC=32'hFFFFFFFC: first fetch pc_4f=0; after advance imem_addr=0.
REQ-040 Assert rst in DROP -> IDLE; next request at RESET_PC. With the macro defined, pc_target=32'h103 -> imem_addr=32'h100 and a one-cycle fetch_misalign pulse.
